// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin sequencer in front of the SDRAM driver: one word per grant,
// active-low start strobes, per-port read data return and sticky hang/no-data flags.
module sdram_port_arbiter #(
    parameter int ROW_W       = 13,
    parameter int COL_W       = 13,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              CLK_160_COMMON,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [1:0]        a_bank,
    input  logic [ROW_W-1:0]  a_row,
    input  logic [COL_W-1:0]  a_col,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [1:0]        b_bank,
    input  logic [ROW_W-1:0]  b_row,
    input  logic [COL_W-1:0]  b_col,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic              sd_start_write,
    output logic              sd_start_read,
    output logic [1:0]        sd_bank,
    output logic [ROW_W-1:0]  sd_row,
    output logic [COL_W-1:0]  sd_col,
    output logic [DATA_W-1:0] sd_wdata,
    input  logic              sd_process,
    input  logic              sd_ready_data,
    input  logic [DATA_W-1:0] sd_rdata,
    output logic              err_timeout,
    output logic              err_noread,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_END, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t            state, state_nxt;
    logic              grant_b, rr_last_b, we_lat, got_data, rdy_prev;
    logic [7:0]        cnt;
    logic [DATA_W-1:0] cap_data;
    logic              pick_b, rd_rise, got_now;
    logic [DATA_W-1:0] rd_word;

    // Tie goes to the port that did not win last time.
    assign pick_b  = b_req && (!a_req || !rr_last_b);
    assign rd_rise = sd_ready_data && !rdy_prev && !we_lat;
    assign got_now = got_data || rd_rise;
    // Data may arrive in the very cycle the driver drops process_flg.
    assign rd_word = rd_rise ? sd_rdata : cap_data;

    always_ff @(posedge CLK_160_COMMON or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        sd_start_write = 1'b1;
        sd_start_read  = 1'b1;
        busy           = 1'b1;
        a_ack          = 1'b0;
        b_ack          = 1'b0;
        a_rvalid       = 1'b0;
        b_rvalid       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if ((a_req || b_req) && !sd_process) state_nxt = ISSUE;
            end
            ISSUE: begin
                sd_start_write = !we_lat;
                sd_start_read  = we_lat;
                if (sd_process)           state_nxt = WAIT_END;
                else if (cnt == CNT_LAST) state_nxt = DONE;
            end
            WAIT_END: begin
                if (!sd_process) state_nxt = DONE;
            end
            DONE: begin
                a_ack     = !grant_b;
                b_ack     = grant_b;
                a_rvalid  = !grant_b && !we_lat && got_data;
                b_rvalid  = grant_b && !we_lat && got_data;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_160_COMMON or posedge reset) begin
        if (reset) begin
            grant_b     <= 1'b0;
            rr_last_b   <= 1'b1;
            we_lat      <= 1'b0;
            got_data    <= 1'b0;
            rdy_prev    <= 1'b0;
            cnt         <= '0;
            cap_data    <= '0;
            sd_bank     <= '0;
            sd_row      <= '0;
            sd_col      <= '0;
            sd_wdata    <= '0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            err_timeout <= 1'b0;
            err_noread  <= 1'b0;
        end else begin
            rdy_prev <= sd_ready_data;
            case (state)
                IDLE: begin
                    if (state_nxt == ISSUE) begin
                        grant_b  <= pick_b;
                        we_lat   <= pick_b ? b_we    : a_we;
                        sd_bank  <= pick_b ? b_bank  : a_bank;
                        sd_row   <= pick_b ? b_row   : a_row;
                        sd_col   <= pick_b ? b_col   : a_col;
                        sd_wdata <= pick_b ? b_wdata : a_wdata;
                        cnt      <= '0;
                        got_data <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (sd_process) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt         <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT_END: begin
                    if (rd_rise) begin
                        cap_data <= sd_rdata;
                        got_data <= 1'b1;
                    end
                    // Port data is loaded on entry to DONE so it is valid alongside rvalid.
                    if (!sd_process && got_now) begin
                        if (grant_b) b_rdata <= rd_word;
                        else         a_rdata <= rd_word;
                    end
                end
                DONE: begin
                    if (!we_lat && !got_data) err_noread <= 1'b1;
                    rr_last_b <= grant_b;
                    got_data  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized bench for sdram_port_arbiter: the bench plays both requesters and the driver,
// predicts every output per cycle from the transaction timeline, and pins key cases literally.
module tb_sdram_port_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [1:0]  a_bank = 0, b_bank = 0;
    logic [12:0] a_row = 0, a_col = 0, b_row = 0, b_col = 0;
    logic [15:0] a_wdata = 0, b_wdata = 0;
    logic        a_ack, a_rvalid, b_ack, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic        sd_start_write, sd_start_read;
    logic [1:0]  sd_bank;
    logic [12:0] sd_row, sd_col;
    logic [15:0] sd_wdata;
    logic        sd_process = 0, sd_ready_data = 0;
    logic [15:0] sd_rdata = 0;
    logic        err_timeout, err_noread, busy;

    sdram_port_arbiter #(.ROW_W(13), .COL_W(13), .DATA_W(16), .TIMEOUT_CYC(T)) dut (
        .CLK_160_COMMON(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_bank(a_bank), .a_row(a_row), .a_col(a_col),
        .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_bank(b_bank), .b_row(b_row), .b_col(b_col),
        .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .sd_start_write(sd_start_write), .sd_start_read(sd_start_read),
        .sd_bank(sd_bank), .sd_row(sd_row), .sd_col(sd_col), .sd_wdata(sd_wdata),
        .sd_process(sd_process), .sd_ready_data(sd_ready_data), .sd_rdata(sd_rdata),
        .err_timeout(err_timeout), .err_noread(err_noread), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle
    logic        e_sw = 1, e_sr = 1, e_busy = 0, e_aack = 0, e_back = 0, e_arv = 0, e_brv = 0;
    logic [15:0] e_ardata = 0, e_brdata = 0, e_wdata = 0;
    logic [1:0]  e_bank = 0;
    logic [12:0] e_row = 0, e_col = 0;
    logic        e_eto = 0, e_enr = 0, enr_next = 0;
    bit          last_b = 1'b1;
    int          errors = 0, checks = 0, cyc = 0;
    int          n_swl = 0, n_srl = 0, n_aack = 0, n_back = 0, n_arv = 0, n_brv = 0;
    bit          ack_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("sd_start_write", 32'(sd_start_write), 32'(e_sw));
        chk("sd_start_read",  32'(sd_start_read),  32'(e_sr));
        chk("busy",           32'(busy),           32'(e_busy));
        chk("a_ack",          32'(a_ack),          32'(e_aack));
        chk("b_ack",          32'(b_ack),          32'(e_back));
        chk("a_rvalid",       32'(a_rvalid),       32'(e_arv));
        chk("b_rvalid",       32'(b_rvalid),       32'(e_brv));
        chk("a_rdata",        32'(a_rdata),        32'(e_ardata));
        chk("b_rdata",        32'(b_rdata),        32'(e_brdata));
        chk("sd_bank",        32'(sd_bank),        32'(e_bank));
        chk("sd_row",         32'(sd_row),         32'(e_row));
        chk("sd_col",         32'(sd_col),         32'(e_col));
        chk("sd_wdata",       32'(sd_wdata),       32'(e_wdata));
        chk("err_timeout",    32'(err_timeout),    32'(e_eto));
        chk("err_noread",     32'(err_noread),     32'(e_enr));
        if (!sd_start_write) n_swl++;
        if (!sd_start_read)  n_srl++;
        if (a_ack) begin n_aack++; ack_q.push_back(1'b0); end
        if (b_ack) begin n_back++; ack_q.push_back(1'b1); end
        if (a_rvalid) n_arv++;
        if (b_rvalid) n_brv++;
    end

    task automatic clr_cnt();
        n_swl = 0; n_srl = 0; n_aack = 0; n_back = 0; n_arv = 0; n_brv = 0;
        ack_q.delete();
    endtask

    task automatic new_cycle();
        @(posedge clk); #1;
        cyc++;
        e_sw = 1; e_sr = 1; e_busy = 0; e_aack = 0; e_back = 0; e_arv = 0; e_brv = 0;
        if (enr_next) begin e_enr = 1; enr_next = 0; end
        sd_process = 0; sd_ready_data = 0; sd_rdata = 16'($urandom);
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic exp_reset();
        e_sw = 1; e_sr = 1; e_busy = 0; e_aack = 0; e_back = 0; e_arv = 0; e_brv = 0;
        e_ardata = 0; e_brdata = 0; e_bank = 0; e_row = 0; e_col = 0; e_wdata = 0;
        e_eto = 0; e_enr = 0; enr_next = 0; last_b = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1; a_req = 0; b_req = 0; sd_process = 0; sd_ready_data = 0;
        exp_reset();
        new_cycle(); new_cycle();
        reset = 0;
    endtask

    task automatic set_req(input bit pb, input bit we, input logic [1:0] bk,
                           input logic [12:0] rw, input logic [12:0] cl, input logic [15:0] wd);
        if (pb) begin b_req = 1; b_we = we; b_bank = bk; b_row = rw; b_col = cl; b_wdata = wd; end
        else    begin a_req = 1; a_we = we; a_bank = bk; a_row = rw; a_col = cl; a_wdata = wd; end
    endtask

    task automatic rnd_req(input bit pb);
        set_req(pb, 1'($urandom), 2'($urandom), 13'($urandom), 13'($urandom), 16'($urandom));
    endtask

    task automatic drop(input bit pb);
        if (pb) b_req = 0; else a_req = 0;
    endtask

    function automatic bit pick_b();
        if (a_req && b_req) return !last_b;
        return b_req;
    endfunction

    // Called in the cycle where requests are visible and process is low.
    // D<0: driver never answers. D>=0: process rises D cycles after the strobe falls,
    // stays high P cycles; r_off in 1..P pulses ready_data in that wait cycle with rv.
    task automatic run_txn(input int D, input int P, input int r_off, input logic [15:0] rv,
                           input bit drops, output bit wb);
        bit          we, got;
        logic [15:0] gd;
        int          n_issue;
        wb = pick_b();
        we = wb ? b_we : a_we;
        got = 0; gd = 0;
        n_issue = (D < 0) ? T : D + 1;
        for (int i = 0; i < n_issue; i++) begin
            new_cycle();
            if (i == 0) begin
                e_bank  = wb ? b_bank  : a_bank;
                e_row   = wb ? b_row   : a_row;
                e_col   = wb ? b_col   : a_col;
                e_wdata = wb ? b_wdata : a_wdata;
            end
            e_busy = 1;
            if (we) e_sw = 0; else e_sr = 0;
            sd_process = (D >= 0 && i == D);
            if (drops && $urandom_range(0, 15) == 0) drop(wb);
        end
        if (D >= 0) begin
            for (int j = 1; j <= P; j++) begin
                new_cycle();
                e_busy = 1;
                sd_process = (j < P);
                if (j == r_off) begin
                    sd_ready_data = 1; sd_rdata = rv;
                    if (!we) begin got = 1; gd = rv; end
                end
                if (drops && $urandom_range(0, 15) == 0) drop(wb);
            end
        end
        new_cycle();
        e_busy = 1;
        if (wb) e_back = 1; else e_aack = 1;
        if (!we && got) begin
            if (wb) begin e_brv = 1; e_brdata = gd; end
            else    begin e_arv = 1; e_ardata = gd; end
        end
        if (D < 0) e_eto = 1;
        if (!we && !got) enr_next = 1;
        last_b = wb;
    endtask

    initial begin
        bit wb, we;
        int D, P, r;
        exp_reset();
        do_reset();

        // Write from A, driver answers 3 cycles after the strobe
        clr_cnt();
        new_cycle();
        set_req(0, 1, 2'd0, 13'd1, 13'd2, 16'h1234);
        run_txn(3, 2, 0, 16'h0, 0, wb);
        new_cycle(); drop(wb); settle();
        chk("t1_strobe_low_cycles", 32'(n_swl), 32'd4);
        chk("t1_a_acks", 32'(n_aack), 32'd1);
        chk("t1_b_acks", 32'(n_back), 32'd0);
        chk("t1_sd_row", 32'(sd_row), 32'd1);
        chk("t1_sd_wdata", 32'(sd_wdata), 32'h1234);

        // Simultaneous requests after reset alternate A,B,A,B
        do_reset();
        clr_cnt();
        new_cycle(); rnd_req(0); rnd_req(1);
        run_txn(1, 1, 0, 16'h0, 0, wb);
        new_cycle(); drop(wb); rnd_req(wb);
        run_txn(0, 2, 0, 16'h0, 0, wb);
        new_cycle(); drop(wb); rnd_req(wb);
        run_txn(2, 1, 0, 16'h0, 0, wb);
        new_cycle(); drop(wb);
        run_txn(0, 1, 0, 16'h0, 0, wb);
        new_cycle(); drop(wb); settle();
        chk("t2_ack_count", 32'(ack_q.size()), 32'd4);
        if (ack_q.size() == 4)
            chk("t2_ack_order", 32'({ack_q[0], ack_q[1], ack_q[2], ack_q[3]}), 32'b0101);

        // B read returning 0xBEEF
        clr_cnt();
        new_cycle(); set_req(1, 0, 2'd3, 13'd77, 13'd5, 16'h0);
        run_txn(1, 3, 2, 16'hBEEF, 0, wb);
        new_cycle(); drop(wb); settle();
        chk("t3_b_rdata", 32'(b_rdata), 32'hBEEF);
        chk("t3_b_rvalid_pulses", 32'(n_brv), 32'd1);
        chk("t3_b_acks", 32'(n_back), 32'd1);

        // A read completing without ready_data
        clr_cnt();
        new_cycle(); set_req(0, 0, 2'd1, 13'd9, 13'd9, 16'h0);
        run_txn(0, 2, 0, 16'h0, 0, wb);
        new_cycle(); drop(wb); settle();
        chk("t5_err_noread", 32'(err_noread), 32'd1);
        chk("t5_a_rvalid_pulses", 32'(n_arv), 32'd0);
        chk("t5_a_acks", 32'(n_aack), 32'd1);

        // A write, driver never answers
        clr_cnt();
        new_cycle(); set_req(0, 1, 2'd2, 13'd3, 13'd4, 16'hCAFE);
        run_txn(-1, 1, 0, 16'h0, 0, wb);
        new_cycle(); drop(wb); settle();
        chk("t4_strobe_low_cycles", 32'(n_swl), 32'd8);
        chk("t4_err_timeout", 32'(err_timeout), 32'd1);
        chk("t4_a_acks", 32'(n_aack), 32'd1);
        chk("t4_a_rvalid_pulses", 32'(n_arv), 32'd0);

        // Reset while waiting for the driver to finish
        clr_cnt();
        new_cycle(); set_req(0, 1, 2'd1, 13'd11, 13'd12, 16'h7777);
        new_cycle();
        e_bank = 2'd1; e_row = 13'd11; e_col = 13'd12; e_wdata = 16'h7777;
        e_busy = 1; e_sw = 0; sd_process = 1;
        new_cycle();
        e_busy = 1; sd_process = 1;
        reset = 1; a_req = 0; exp_reset();
        new_cycle(); sd_process = 1;
        new_cycle();
        reset = 0;
        new_cycle(); settle();
        chk("t6_acks_after_reset", 32'(n_aack + n_back), 32'd0);
        chk("t6_err_timeout_cleared", 32'(err_timeout), 32'd0);
        new_cycle(); set_req(0, 0, 2'd2, 13'd20, 13'd21, 16'h0);
        run_txn(2, 2, 1, 16'h5A5A, 0, wb);
        new_cycle(); drop(wb); settle();
        chk("t6_a_rdata_after", 32'(a_rdata), 32'h5A5A);
        chk("t6_a_acks_after", 32'(n_aack), 32'd1);

        // Randomized traffic
        do_reset();
        for (int t = 0; t < 300; t++) begin
            new_cycle();
            drop(wb);
            if (!a_req && !b_req && $urandom_range(0, 3) == 0) new_cycle();
            if (!a_req && $urandom_range(0, 1) == 1) rnd_req(0);
            if (!b_req && $urandom_range(0, 1) == 1) rnd_req(1);
            if (!a_req && !b_req) rnd_req(1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                int ns = $urandom_range(1, 3);
                for (int k = 0; k < ns; k++) begin
                    sd_process = 1;
                    new_cycle();
                end
            end
            we = pick_b() ? b_we : a_we;
            D = (we && $urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, T - 1);
            P = $urandom_range(1, 4);
            r = ($urandom_range(0, 3) != 0) ? $urandom_range(1, P) : 0;
            run_txn(D, P, r, 16'($urandom), 1, wb);
        end
        new_cycle(); drop(wb);
        new_cycle(); settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
